// File: rtl/debug_bus_arbiter.sv
// debug_bus_arbiter: round-robin arbiter sharing the debug register port
// between M0 (external debug host) and M1 (CPU MMIO path).
// Latency: request seen in IDLE at cycle N -> strobe at N+1 -> ack at N+2.
// Backpressure: a requester holds req until ack; the loser of a tie, or a
// requester arriving while the other is being served, waits for the next IDLE.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m0_req/wr/addr/wdata (in)     M0 request, direction, byte address, data
//   m0_ack/err/rdata (out)        M0 completion pulse, error flag, read data
//   m1_*                          same set for M1
//   debug_addr/read/write/
//     write_data (out)            register-file access port
//   debug_read_data (in)          combinational read data from register file
//   busy (out)                    high whenever the FSM is not in IDLE
module debug_bus_arbiter #(
  parameter logic [31:0] DBG_BASE = 32'h2000_0000,
  parameter int unsigned NUM_REGS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] debug_addr,
  output logic        debug_read,
  output logic        debug_write,
  output logic [31:0] debug_write_data,
  input  logic [31:0] debug_read_data,
  output logic        busy
);

  localparam logic [31:0] DBG_END = DBG_BASE + 32'(4 * NUM_REGS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        last_m1;     // 1: M1 was granted last, so M0 wins the next tie
  logic        gnt_m1;      // master owning the access in flight
  logic        acc_wr;
  logic        acc_err;

  logic        grant;
  logic        grant_m1;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_legal;
  logic [31:0] rdata_cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_m1   = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant      = 1'b1;
          grant_m1   = (m0_req && m1_req) ? !last_m1 : m1_req;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sel_wr    = grant_m1 ? m1_wr    : m0_wr;
  assign sel_addr  = grant_m1 ? m1_addr  : m0_addr;
  assign sel_wdata = grant_m1 ? m1_wdata : m0_wdata;
  assign sel_legal = (sel_addr >= DBG_BASE) && (sel_addr < DBG_END) &&
                     (sel_addr[1:0] == 2'b00);

  // Writes and rejected accesses return zero data.
  assign rdata_cap = (!acc_err && !acc_wr) ? debug_read_data : 32'd0;

  // debug_addr / debug_write_data double as the payload latch: they are
  // loaded once at grant and ignore later payload changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_m1          <= 1'b1;
      gnt_m1           <= 1'b0;
      acc_wr           <= 1'b0;
      acc_err          <= 1'b0;
      debug_addr       <= 32'd0;
      debug_write_data <= 32'd0;
      debug_read       <= 1'b0;
      debug_write      <= 1'b0;
      m0_ack           <= 1'b0;
      m0_err           <= 1'b0;
      m0_rdata         <= 32'd0;
      m1_ack           <= 1'b0;
      m1_err           <= 1'b0;
      m1_rdata         <= 32'd0;
      busy             <= 1'b0;
    end else begin
      debug_read <= 1'b0;
      debug_write <= 1'b0;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= 32'd0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= 32'd0;
      busy       <= (state_next != IDLE);

      if (grant) begin
        last_m1          <= grant_m1;
        gnt_m1           <= grant_m1;
        acc_wr           <= sel_wr;
        acc_err          <= !sel_legal;
        debug_addr       <= sel_addr;
        debug_write_data <= sel_wdata;
        debug_read       <= sel_legal && !sel_wr;
        debug_write      <= sel_legal && sel_wr;
      end

      // Response registers load at the end of ACCESS so they are visible in RESP.
      if (state == ACCESS) begin
        if (gnt_m1) begin
          m1_ack   <= 1'b1;
          m1_err   <= acc_err;
          m1_rdata <= rdata_cap;
        end else begin
          m0_ack   <= 1'b1;
          m0_err   <= acc_err;
          m0_rdata <= rdata_cap;
        end
      end
    end
  end

endmodule
